// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: synchronizes raw lines and runs the claim/complete handshake.
// Optional macro PLIC_GW_EDGE_TRIG_EN adds per-source edge triggering with a 2-bit edge backlog counter.
module plic_gateway #(
    parameter int SRC_NUM = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SRC_NUM-1:0] src_int,
    input  logic [SRC_NUM-1:0] src_en,
`ifdef PLIC_GW_EDGE_TRIG_EN
    input  logic [SRC_NUM-1:0] edge_mode,
`endif
    input  logic               claim_req,
    input  logic [ID_W-1:0]    claim_id,
    input  logic               complete_req,
    input  logic [ID_W-1:0]    complete_id,
    output logic [SRC_NUM-1:0] ip,
    output logic [SRC_NUM-1:0] inflight
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        CLAIMED = 2'd2
    } state_t;

    logic [SRC_NUM-1:0] sync1_reg;
    logic [SRC_NUM-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= src_int;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef PLIC_GW_EDGE_TRIG_EN
    logic [SRC_NUM-1:0] sync_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_d_reg <= '0;
        end else begin
            sync_d_reg <= sync2_reg;
        end
    end

    function automatic logic [1:0] sat2(input logic [2:0] x);
        return (x > 3'd3) ? 2'd3 : x[1:0];
    endfunction
`endif

    genvar gi;
    generate
        for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
            state_t state_reg, state_next;
            logic   ip_reg, ip_next;
            logic   inflight_reg, inflight_next;
            logic   trig;
            logic   claim_hit;
            logic   complete_hit;

            // IDs outside 0..SRC_NUM-1 match no source and therefore fall through untouched.
            assign claim_hit    = claim_req    && (claim_id    == ID_W'(gi));
            assign complete_hit = complete_req && (complete_id == ID_W'(gi));

`ifdef PLIC_GW_EDGE_TRIG_EN
            logic [1:0] cnt_reg, cnt_next;
            logic       edge_pulse;
            logic [2:0] pend_edges;

            assign edge_pulse = edge_mode[gi] & sync2_reg[gi] & ~sync_d_reg[gi];
            assign trig       = edge_mode[gi] ? edge_pulse : sync2_reg[gi];
            // Backlog including an edge arriving this very cycle, so it is never lost on complete.
            assign pend_edges = {1'b0, cnt_reg} + {2'b00, edge_pulse};

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 2'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
`else
            assign trig = sync2_reg[gi];
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg    <= IDLE;
                    ip_reg       <= 1'b0;
                    inflight_reg <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    ip_reg       <= ip_next;
                    inflight_reg <= inflight_next;
                end
            end

            always_comb begin
                state_next = state_reg;
`ifdef PLIC_GW_EDGE_TRIG_EN
                cnt_next   = cnt_reg;
`endif
                case (state_reg)
                    IDLE: begin
                        if (trig && src_en[gi]) begin
                            state_next = PEND;
                        end
                    end
                    PEND: begin
`ifdef PLIC_GW_EDGE_TRIG_EN
                        cnt_next = sat2(pend_edges);
`endif
                        if (claim_hit) begin
                            state_next = CLAIMED;
                        end
                    end
                    CLAIMED: begin
`ifdef PLIC_GW_EDGE_TRIG_EN
                        cnt_next = sat2(pend_edges);
                        if (complete_hit) begin
                            if (pend_edges != 3'd0) begin
                                state_next = PEND;
                                cnt_next   = sat2(pend_edges - 3'd1);
                            end else begin
                                state_next = IDLE;
                            end
                        end
`else
                        if (complete_hit) begin
                            state_next = IDLE;
                        end
`endif
                    end
                    default: state_next = IDLE;
                endcase
            end

            // Outputs are registered decodes of the next state, so no request input reaches them combinationally.
            always_comb begin
                ip_next       = (state_next == PEND) && src_en[gi];
                inflight_next = (state_next == CLAIMED);
            end

            assign ip[gi]       = ip_reg;
            assign inflight[gi] = inflight_reg;
        end
    endgenerate

endmodule
